bcd_seven_seg_scan: RTL and testbench

//  Downstream consumer of the 32-bit packed BCD word (8 digits, digit0 = [3:0]).

---
 rtl/bcd_seven_seg_scan.sv | 149 ++++++++++++++
 tb/tb_bcd_seven_seg_scan.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_seven_seg_scan.sv
// Time-multiplexed 7-segment driver for a packed BCD word with leading-zero
// blanking and frame-boundary (tear-free) display update.
module bcd_seven_seg_scan #(
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bcd_in,
  input  logic        bcd_valid,
  input  logic [7:0]  dp_in,
  input  logic        en,
  output logic [7:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned      PW         = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [2:0]       IDX_LAST   = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]       ANODE_OFF  = {8{ACTIVE_LOW}};
  localparam logic [6:0]       SEG_OFF    = {7{ACTIVE_LOW}};

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   shadow_q, shadow_d, disp_q, disp_d;
  logic [7:0]    shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
  logic          pending_q, pending_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          slot_end, boundary, nz_above;
  logic [7:0]    keep;
  logic [3:0]    nib;
  logic [6:0]    seg_on;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    shadow_dp_d  = shadow_dp_q;
    disp_d       = disp_q;
    disp_dp_d    = disp_dp_q;
    pending_d    = pending_q;
    anode_d      = ANODE_OFF;
    seg_d        = SEG_OFF;
    dp_d         = ACTIVE_LOW;
    nz_above     = 1'b0;
    keep         = '0;

    slot_end     = en && (presc_q == PRESC_LAST);
    boundary     = slot_end && (idx_q == IDX_LAST);
    frame_done_d = boundary;

    if (!en || slot_end) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
    if (slot_end) begin
      idx_d = boundary ? 3'd0 : idx_q + 3'd1;
    end

    if (bcd_valid) begin
      shadow_d    = bcd_in;
      shadow_dp_d = dp_in;
      pending_d   = 1'b1;
    end
    // A strobe on the boundary cycle goes straight to the display.
    if (boundary && (pending_q || bcd_valid)) begin
      disp_d    = bcd_valid ? bcd_in : shadow_q;
      disp_dp_d = bcd_valid ? dp_in : shadow_dp_q;
      pending_d = 1'b0;
    end

    for (int i = 7; i >= 0; i--) begin
      if (i < int'(NUM_DIGITS) && disp_q[4*i +: 4] != 4'h0) begin
        nz_above = 1'b1;
      end
      keep[i] = nz_above || (i == 0) || !BLANK_LEADING;
    end

    nib    = disp_q[{idx_q, 2'b00} +: 4];
    seg_on = keep[idx_q] ? decode(nib) : 7'h00;

    if (en) begin
      anode_d = (8'h01 << idx_q) ^ ANODE_OFF;
      seg_d   = seg_on ^ SEG_OFF;
      dp_d    = disp_dp_q[idx_q] ^ ACTIVE_LOW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      anode_q      <= ANODE_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= ACTIVE_LOW;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign anode      = anode_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_seven_seg_scan.sv
// Directed + randomized bench for bcd_seven_seg_scan against an arithmetic
// model of slot timing, frame updates, decoding and blanking.
module tb_bcd_seven_seg_scan;

  localparam int R = 4;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst, bcd_valid, en;
  logic [31:0] bcd_in;
  logic [7:0]  dp_in;
  logic [7:0]  anode, anode_nb;
  logic [6:0]  seg, seg_nb;
  logic        dp, dp_nb, fd, fd_nb;

  always #5 clk = ~clk;

  bcd_seven_seg_scan #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_valid(bcd_valid), .dp_in(dp_in),
    .en(en), .anode(anode), .seg(seg), .dp(dp), .frame_done(fd)
  );

  bcd_seven_seg_scan #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)
  ) dut_nb (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_valid(bcd_valid), .dp_in(dp_in),
    .en(en), .anode(anode_nb), .seg(seg_nb), .dp(dp_nb), .frame_done(fd_nb)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: m_tick counts enabled cycles; slot and digit follow by division.
  int          m_tick;
  logic [31:0] m_shadow, m_disp;
  logic [7:0]  m_sdp, m_ddp;
  bit          m_pend;
  logic [7:0]  e_anode;
  logic [6:0]  e_seg, e_seg_nb;
  logic        e_dp, e_fd;
  logic [6:0]  lut [16];

  function automatic logic [6:0] exp_seg(int idx, bit bl);
    logic [31:0] upper;
    logic [3:0]  n;
    upper = m_disp >> (4 * idx);
    n     = upper[3:0];
    if (bl && idx > 0 && upper == 32'h0) return 7'h7F;
    return ~lut[n];
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    int idx;
    bit bnd;
    if (rst) begin
      m_tick = 0; m_shadow = '0; m_disp = '0; m_sdp = '0; m_ddp = '0; m_pend = 0;
      e_anode = 8'hFF; e_seg = 7'h7F; e_seg_nb = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      idx = (m_tick / R) % N;
      if (en) begin
        e_anode  = ~(8'h01 << idx);
        e_seg    = exp_seg(idx, 1'b1);
        e_seg_nb = exp_seg(idx, 1'b0);
        e_dp     = ~m_ddp[idx];
        m_tick++;
        bnd = (m_tick % (R * N)) == 0;
      end else begin
        e_anode = 8'hFF; e_seg = 7'h7F; e_seg_nb = 7'h7F; e_dp = 1'b1;
        m_tick  = (m_tick / R) * R;
        bnd     = 0;
      end
      e_fd = bnd;
      if (bcd_valid) begin
        m_shadow = bcd_in; m_sdp = dp_in; m_pend = 1;
      end
      if (bnd && m_pend) begin
        m_disp = m_shadow; m_ddp = m_sdp; m_pend = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("anode", anode, e_anode);
    chk("seg", {1'b0, seg}, {1'b0, e_seg});
    chk("dp", {7'h0, dp}, {7'h0, e_dp});
    chk("frame_done", {7'h0, fd}, {7'h0, e_fd});
    chk("seg_noblank", {1'b0, seg_nb}, {1'b0, e_seg_nb});
    chk("anode_noblank", anode_nb, e_anode);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic strobe(input logic [31:0] v, input logic [7:0] d);
    bcd_in = v; dp_in = d; bcd_valid = 1'b1;
    step();
    bcd_valid = 1'b0;
  endtask

  initial begin
    int guard;
    int nz;
    lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    rst = 1'b1; en = 1'b0; bcd_valid = 1'b0; bcd_in = '0; dp_in = '0;
    #2;

    // Reset and all-zero scan
    run(3);
    chk("rst_anode", anode, 8'hFF);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_dp", {7'h0, dp}, 8'h01);
    chk("rst_fd", {7'h0, fd}, 8'h00);
    rst = 1'b0; en = 1'b1;
    run(70);

    // Mid-frame strobe, visible only after the frame boundary
    run(9);
    strobe(32'h0001_2345, 8'h00);
    run(70);

    // Dash for A; no-blank instance shows zeros on 0x7
    strobe(32'h0000_000A, 8'h00);
    run(40);
    strobe(32'h0000_0007, 8'h00);
    run(40);

    // Two strobes in one frame, then one on the boundary cycle
    strobe(32'h11, 8'h00);
    run(3);
    strobe(32'h22, 8'h00);
    guard = 0;
    while ((m_tick % (R * N)) != (R * N - 1) && guard < 64) begin
      step(); guard++;
    end
    strobe(32'h33, 8'h00);
    run(70);

    // Pause at digit 3
    guard = 0;
    while (((m_tick / R) % N) != 3 && guard < 64) begin
      step(); guard++;
    end
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(40);

    // Reset mid-frame discards pending strobe; then dp on digit 0
    strobe(32'h0000_9876, 8'hFF);
    run(5);
    rst = 1'b1;
    step();
    chk("rst2_anode", anode, 8'hFF);
    rst = 1'b0;
    run(20);
    strobe(32'h0000_0000, 8'h01);
    run(70);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      bcd_valid = ($urandom % 8) == 0;
      nz        = $urandom_range(0, 8);
      bcd_in    = (nz == 8) ? $urandom : ($urandom & ((32'h1 << (4 * nz)) - 32'h1));
      dp_in     = 8'($urandom);
      if (($urandom % 40) == 0) en = ~en;
      rst = ($urandom % 300) == 0;
      step();
    end
    rst = 1'b0; bcd_valid = 1'b0;
    run(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
